vga_capture: RTL and testbench
==============================

# vga_capture

Video-input capture engine: samples a 640x400 raster stream (vs/de/RGB888) in the pixel clock domain, quantizes each visible pixel to RGB332, and emits one memory write per pixel in raster order. It is the producer-side counterpart of the 160x100/640x400 VGA scan-out controller, filling the same byte-per-pixel framebuffer layout through a cpu_wr/cpu_addr/cpu_data-style write port. It is used for loopback test and frame grab.

## Interface
- H, 640, visible pixels per line (de-high run length)
- V, 400, visible lines per frame
- VS_POL, 1, active level of vs (1 = positive vsync)
- pclk, input, 1, pixel clock; all logic on rising edge
- reset, input, 1, asynchronous, active-high
- arm, input, 1, single-cycle request to capture; ignored unless state is IDLE
- cont, input, 1, continuous mode; sampled at each frame end
- vs, input, 1, vertical sync, polarity per VS_POL
- de, input, 1, data enable, high during visible pixels
- r, g, b, input, 8 each, pixel colour, valid when de=1
- mem_wr, output, 1, write strobe, one cycle per pixel
- mem_addr, output, 32, pixel index 0..H*V-1
- mem_data, output, 8, RGB332 pixel
- busy, output, 1, state != IDLE
- done, output, 1, one-cycle pulse on frame completion
- err, output, 1, sticky error flag; cleared by reset or accepted arm

## Operation
- Quantization: mem_data = {r[7:5], g[7:5], b[7:6]}. This is the exact inverse of scan-out bit replication, so RGB332 round-trips losslessly.
- Edge detect, using registered vs_d and de_d:
  - vs_edge = (vs==VS_POL) && (vs_d!=VS_POL)
  - de_fall = de_d && !de
- States:
  - IDLE: arm=1 -> WAIT_VS; clear err, pix_cnt, line_cnt, addr.
  - WAIT_VS: vs_edge -> WAIT_DE; addr cleared to 0.
  - WAIT_DE: de=1 -> CAPTURE, and this pixel is written.
  - CAPTURE:
    - each de=1 cycle: write pixel, addr+1, pix_cnt+1.
    - de_fall: if pix_cnt != H then set err, go to IDLE (abort). Otherwise line_cnt+1 and pix_cnt cleared.
    - When line_cnt reaches V: done pulse, then WAIT_VS if cont=1, else IDLE.
- vs_edge in CAPTURE or WAIT_DE before V lines complete: set err, no done, abort to WAIT_VS if cont=1, else IDLE.
- pix_cnt saturates logic: if pix_cnt would exceed H (de held too long), further pixels are not written, and err is set at de_fall.
- mem_addr never exceeds H*V-1. Writes are suppressed whenever addr == H*V.
- arm in any non-IDLE state: no effect. cont deasserted mid-frame: current frame completes, then IDLE.

## Timing
- Reset (async) forces: state IDLE, mem_wr=0, mem_addr=0, mem_data=0, busy=0, done=0, err=0. Reset mid-frame drops mem_wr in the same instant; no partial-write recovery.
- Latency: pixel presented with de=1 at edge N appears as mem_wr=1 with its addr/data after edge N+1 (one register stage). No backpressure; the sink accepts one write per pclk.
- First written pixel: first de=1 cycle after the vs_edge that followed arm. A de=1 in the same cycle as vs_edge is not captured.
- done asserts the cycle after the de_fall that completes line V. It is coincident with nothing else, lasts 1 cycle, and is never asserted on an aborted frame.
- busy goes high the cycle after arm is accepted. It goes low the cycle after the return to IDLE.
- Within a frame, addr is strictly sequential: pixel (x,y) is written at y*H+x.

## Test plan
- Single frame, H=8 V=4, pixel value = index, arm then vs pulse then 4 lines of 8 de cycles -> 32 writes, addr 0..31, done once one cycle after last de_fall, busy low afterward.
- Colour quantization: r=0xE0 g=0x1C b=0xC0 -> mem_data=0xE3; r=0xFF g=0xFF b=0xFF -> 0xFF; r=0x1F g=0x1F b=0x3F -> 0x00.
- Short line: third line has 7 de cycles -> err=1 at de_fall, no done, no further writes, state IDLE; next arm clears err.
- Early vsync: vs_edge after 2 of 4 lines with cont=1 -> err=1, no done, writes restart at addr 0 on next frame, and that frame completes with done.
- Continuous mode: cont=1, three back-to-back frames -> three done pulses, addr restarts at 0 each frame, arm pulses during capture ignored.
- Async reset asserted mid-line (addr=13) -> mem_wr, busy, mem_addr all 0 immediately; after release, no writes until arm plus vs_edge.

Source files
------------

// File: rtl/vga_capture.sv
// vga_capture
//   Captures a raster video stream (vs/de/RGB888) into a byte-per-pixel
//   framebuffer. Every visible pixel is quantized to RGB332 and emitted as
//   one memory write, in raster order, one pclk after it was presented.
//
// Ports
//   pclk, reset        pixel clock (rising edge), async active-high reset
//   arm                one-cycle capture request, honoured only when idle
//   cont               continuous mode, looked at when a frame ends
//   vs, de, r, g, b    incoming video: sync, data enable, colour
//   mem_wr/addr/data   write strobe, pixel index (y*H+x), RGB332 byte
//   busy               engine is not idle
//   done               one-cycle pulse after the last line of a good frame
//   err                sticky: bad line length or early vsync; cleared by
//                      reset or by an accepted arm
module vga_capture #(
  parameter int   H      = 640,
  parameter int   V      = 400,
  parameter logic VS_POL = 1'b1
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        arm,
  input  logic        cont,
  input  logic        vs,
  input  logic        de,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_VS = 2'd1;
  localparam logic [1:0] ST_WAIT_DE = 2'd2;
  localparam logic [1:0] ST_CAPTURE = 2'd3;

  // pix_cnt must be able to hold H+1 so an over-long line stays detectable.
  localparam int PW = $clog2(H + 2);
  localparam int LW = $clog2(V + 1);

  localparam logic [31:0]   FRAME_PIX = 32'(H * V);
  localparam logic [PW-1:0] PIX_FULL  = PW'(H);
  localparam logic [PW-1:0] PIX_OVER  = PW'(H + 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(V - 1);

  logic [1:0]    state_reg, state_next;
  logic          vs_d_reg, de_d_reg;
  logic [PW-1:0] pix_cnt_reg, pix_cnt_next;
  logic [LW-1:0] line_cnt_reg, line_cnt_next;
  logic [31:0]   addr_reg, addr_next;
  logic          err_reg, err_next;
  logic          wr_reg, wr_next;
  logic [31:0]   wr_addr_reg, wr_addr_next;
  logic [7:0]    wr_data_reg, wr_data_next;
  logic          done_reg, done_next;

  logic          vs_edge;
  logic          de_fall;
  logic          take_pixel;
  logic [7:0]    pixel_rgb332;

  // Low colour bits are discarded by the RGB332 quantization.
  logic          unused_colour_bits;
  assign unused_colour_bits = &{1'b0, r[4:0], g[4:0], b[5:0]};

  assign vs_edge      = (vs == VS_POL) && (vs_d_reg != VS_POL);
  assign de_fall      = de_d_reg && !de;
  assign pixel_rgb332 = {r[7:5], g[7:5], b[7:6]};

  always_comb begin
    state_next    = state_reg;
    pix_cnt_next  = pix_cnt_reg;
    line_cnt_next = line_cnt_reg;
    addr_next     = addr_reg;
    err_next      = err_reg;
    wr_next       = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    done_next     = 1'b0;
    take_pixel    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (arm) begin
          state_next    = ST_WAIT_VS;
          err_next      = 1'b0;
          pix_cnt_next  = '0;
          line_cnt_next = '0;
          addr_next     = '0;
        end
      end
      ST_WAIT_VS: begin
        // A de=1 coincident with the sync edge is deliberately not captured.
        if (vs_edge) begin
          state_next    = ST_WAIT_DE;
          pix_cnt_next  = '0;
          line_cnt_next = '0;
          addr_next     = '0;
        end
      end
      ST_WAIT_DE: begin
        if (vs_edge) begin
          err_next   = 1'b1;
          state_next = cont ? ST_WAIT_VS : ST_IDLE;
        end else if (de) begin
          state_next = ST_CAPTURE;
          take_pixel = 1'b1;
        end
      end
      default: begin // ST_CAPTURE
        if (de_fall) begin
          if (pix_cnt_reg != PIX_FULL) begin
            // Short or over-long line: abort the frame.
            err_next   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            pix_cnt_next  = '0;
            line_cnt_next = line_cnt_reg + 1'b1;
            if (line_cnt_reg == LAST_LINE) begin
              done_next  = 1'b1;
              state_next = cont ? ST_WAIT_VS : ST_IDLE;
            end
          end
        end else if (vs_edge) begin
          err_next   = 1'b1;
          state_next = cont ? ST_WAIT_VS : ST_IDLE;
        end else if (de) begin
          take_pixel = 1'b1;
        end
      end
    endcase

    // pix_cnt saturates at H+1; pixels beyond H are counted but not written.
    if (take_pixel) begin
      if (pix_cnt_reg != PIX_OVER) begin
        pix_cnt_next = pix_cnt_reg + 1'b1;
      end
      if ((pix_cnt_reg < PIX_FULL) && (addr_reg != FRAME_PIX)) begin
        wr_next      = 1'b1;
        wr_addr_next = addr_reg;
        wr_data_next = pixel_rgb332;
        addr_next    = addr_reg + 32'd1;
      end
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      // Start with vs_d at the active level so a held sync is not an edge.
      vs_d_reg     <= VS_POL;
      de_d_reg     <= 1'b0;
      pix_cnt_reg  <= '0;
      line_cnt_reg <= '0;
      addr_reg     <= '0;
      err_reg      <= 1'b0;
      wr_reg       <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      vs_d_reg     <= vs;
      de_d_reg     <= de;
      pix_cnt_reg  <= pix_cnt_next;
      line_cnt_reg <= line_cnt_next;
      addr_reg     <= addr_next;
      err_reg      <= err_next;
      wr_reg       <= wr_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
      done_reg     <= done_next;
    end
  end

  assign mem_wr   = wr_reg;
  assign mem_addr = wr_addr_reg;
  assign mem_data = wr_data_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign done     = done_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture
//   Randomized bench for vga_capture (H=8, V=4). A frame-level model tracks
//   whether the engine is idle, armed or inside a frame, and queues the
//   writes that must appear. A negedge monitor matches every mem_wr against
//   that queue.
module tb_vga_capture;

  localparam int   H      = 8;
  localparam int   V      = 4;
  localparam logic VS_POL = 1'b1;

  logic        pclk;
  logic        reset;
  logic        arm;
  logic        cont;
  logic        vs;
  logic        de;
  logic [7:0]  r, g, b;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data;
  logic        busy;
  logic        done;
  logic        err;

  vga_capture #(.H(H), .V(V), .VS_POL(VS_POL)) dut (
    .pclk(pclk), .reset(reset), .arm(arm), .cont(cont),
    .vs(vs), .de(de), .r(r), .g(g), .b(b),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done), .err(err)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_FRAME = 2;

  wr_t  exp_q[$];
  int   m_state = M_IDLE;
  int   m_line, m_pix, m_addr;
  logic m_err = 1'b0;
  int   done_exp = 0;
  int   done_seen = 0;

  logic [7:0] dir_r[3] = '{8'hE0, 8'hFF, 8'h1F};
  logic [7:0] dir_g[3] = '{8'h1C, 8'hFF, 8'h1F};
  logic [7:0] dir_b[3] = '{8'hC0, 8'hFF, 8'h3F};
  logic [7:0] dir_q[3] = '{8'hE3, 8'hFF, 8'h00};

  // 8 red levels, 8 green levels, 4 blue levels packed as R*32 + G*4 + B.
  function automatic logic [7:0] quant(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    int v;
    v = (int'(rr) / 32) * 32 + (int'(gg) / 32) * 4 + (int'(bb) / 64);
    return 8'(v);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge pclk) begin
    if (!reset) begin
      if (mem_wr) begin
        if (exp_q.size() == 0) begin
          check("spurious_wr", 32'(mem_wr), 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", mem_addr, e.addr);
          check("wr_data", 32'(mem_data), 32'(e.data));
          $display("write addr=%0d data=0x%02h", mem_addr, mem_data);
        end
      end
      if (done) begin
        done_seen++;
        check("done_alone", 32'(mem_wr), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic a, input logic v, input logic d,
                     input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    arm = a;
    vs  = v ? VS_POL : ~VS_POL;
    de  = d;
    r   = rr;
    g   = gg;
    b   = bb;
    @(posedge pclk);
    #1;
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic do_arm();
    if (m_state == M_IDLE) begin
      m_state = M_ARMED;
      m_err   = 1'b0;
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check("busy_after_arm", 32'(busy), 32'(m_state != M_IDLE));
    check("err_after_arm", 32'(err), 32'(m_err));
  endtask

  task automatic do_vsync();
    if (m_state == M_ARMED) begin
      m_state = M_FRAME;
      m_addr  = 0;
      m_line  = 0;
      m_pix   = 0;
    end else if (m_state == M_FRAME) begin
      m_err   = 1'b1;
      m_state = cont ? M_ARMED : M_IDLE;
    end
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    blank(2);
    check("err_after_vs", 32'(err), 32'(m_err));
    check("busy_after_vs", 32'(busy), 32'(m_state != M_IDLE));
  endtask

  // One de=1 cycle; mode 0 = random colour, mode 1 = directed colour table.
  task automatic pixel(input int mode, input int i, input logic a);
    logic [7:0] rr, gg, bb, q;
    if (mode == 1) begin
      rr = dir_r[i % 3]; gg = dir_g[i % 3]; bb = dir_b[i % 3]; q = dir_q[i % 3];
    end else begin
      rr = 8'($urandom); gg = 8'($urandom); bb = 8'($urandom); q = quant(rr, gg, bb);
    end
    if (m_state == M_FRAME) begin
      if (m_pix < H && m_addr < H * V) begin
        exp_q.push_back('{addr: 32'(m_addr), data: q});
        m_addr++;
      end
      m_pix++;
    end
    if (a && m_state == M_IDLE) begin
      m_state = M_ARMED;
      m_err   = 1'b0;
    end
    cyc(a, 1'b0, 1'b1, rr, gg, bb);
  endtask

  task automatic send_line(input int n, input int mode, input int arm_at);
    logic exp_done;
    for (int i = 0; i < n; i++) pixel(mode, i, arm_at == i);
    exp_done = 1'b0;
    if (m_state == M_FRAME) begin
      if (m_pix != H) begin
        m_err   = 1'b1;
        m_state = M_IDLE;
      end else begin
        m_line++;
        m_pix = 0;
        if (m_line == V) begin
          exp_done = 1'b1;
          done_exp++;
          m_state = cont ? M_ARMED : M_IDLE;
        end
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00); // de_fall cycle
    check("done_pulse", 32'(done), 32'(exp_done));
    check("err_line_end", 32'(err), 32'(m_err));
    check("busy_line_end", 32'(busy), 32'(m_state != M_IDLE));
    blank(1);
    check("done_width", 32'(done), 32'd0);
    blank($urandom_range(0, 2));
  endtask

  task automatic flush(input string tag);
    blank(3);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_done_cnt"}, 32'(done_seen), 32'(done_exp));
    $display("scenario %s done: checks=%0d", tag, checks);
  endtask

  initial begin
    reset = 1'b1;
    arm = 1'b0; cont = 1'b0; vs = ~VS_POL; de = 1'b0;
    r = 8'h00; g = 8'h00; b = 8'h00;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_data", 32'(mem_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    blank(2);

    // Single frame, random colours.
    do_arm();
    blank(2);
    do_vsync();
    for (int y = 0; y < V; y++) send_line(H, 0, -1);
    check("busy_after_frame", 32'(busy), 32'd0);
    flush("single");

    // Directed quantization values.
    do_arm();
    do_vsync();
    for (int y = 0; y < V; y++) send_line(H, 1, -1);
    flush("quant");

    // Short third line aborts; following line is not written; arm clears err.
    do_arm();
    do_vsync();
    send_line(H, 0, -1);
    send_line(H, 0, -1);
    send_line(H - 1, 0, -1);
    send_line(H, 0, -1);
    check("short_err", 32'(err), 32'd1);
    check("short_idle", 32'(busy), 32'd0);
    flush("short");
    do_arm();

    // Over-long first line: extra pixels dropped, err at de_fall.
    do_vsync();
    send_line(H + 2, 0, -1);
    flush("long");

    // Early vsync in continuous mode, then a clean frame.
    cont = 1'b1;
    do_arm();
    do_vsync();
    send_line(H, 0, -1);
    send_line(H, 0, -1);
    do_vsync();
    check("early_err", 32'(err), 32'd1);
    do_vsync();
    for (int y = 0; y < V; y++) send_line(H, 0, -1);
    flush("early_vs");

    // Continuous: three frames, arm pulses mid-line ignored, cont dropped in the last.
    for (int f = 0; f < 3; f++) begin
      do_vsync();
      for (int y = 0; y < V; y++) begin
        if (f == 2 && y == V - 1) cont = 1'b0;
        send_line(H, 0, (y == 1) ? 3 : -1);
      end
    end
    check("cont_idle", 32'(busy), 32'd0);
    flush("continuous");

    // Randomized frames with occasional bad lines and early syncs.
    for (int k = 0; k < 8; k++) begin
      int nl;
      cont = 1'($urandom);
      if (m_state == M_IDLE) do_arm();
      do_vsync();
      nl = $urandom_range(2, V);
      for (int y = 0; y < nl; y++) begin
        int len;
        case ($urandom_range(0, 7))
          0:       len = H - 1;
          1:       len = H + 1;
          default: len = H;
        endcase
        send_line(len, 0, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1);
      end
    end
    cont = 1'b0;
    if (m_state == M_FRAME) do_vsync();
    flush("random");

    // Async reset mid-line while pixel 13 is on the write port.
    if (m_state == M_IDLE) do_arm();
    do_vsync();
    send_line(H, 0, -1);
    for (int i = 0; i < 6; i++) pixel(0, i, 1'b0);
    check("pre_reset_wr", 32'(mem_wr), 32'd1);
    check("pre_reset_addr", mem_addr, 32'd13);
    #2;
    reset = 1'b1;
    exp_q.delete();
    m_state = M_IDLE;
    m_err   = 1'b0;
    #1;
    check("arst_mem_wr", 32'(mem_wr), 32'd0);
    check("arst_mem_addr", mem_addr, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    de = 1'b0;
    @(posedge pclk);
    #1;
    reset = 1'b0;
    blank(2);
    send_line(H, 0, -1);   // not armed
    do_vsync();            // not armed
    send_line(H, 0, -1);
    do_arm();
    send_line(H, 0, -1);   // armed but no sync yet
    do_vsync();
    for (int y = 0; y < V; y++) send_line(H, 0, -1);
    flush("reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
